// File: rtl/apb_pkg.sv
// apb_pkg: shared APB state encoding and default bus widths for requester and responder
package apb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;
  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: saturating wait-state counter that flags the edge on which the limit is reached
module apb_timeout_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  // expired is true on the stalled edge that would bring the count up to limit; limit 0 never expires
  assign expired = enable && limit != '0 && cnt_q == limit - 1'b1;
  // clear wins, otherwise count stalled edges and stick at all-ones
  always_comb cnt_d = clear ? '0 : (enable && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/apb_master.sv
// apb_master: single-initiator APB requester, one SETUP+ACCESS transfer per accepted command
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  apb_state_t state_q, state_d;
  logic psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic accept, expired;
  assign cmd_ready = presetn && state_q == IDLE;
  assign accept    = cmd_valid && cmd_ready;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  apb_timeout_ctr #(.W(CW)) u_tmo (
    .clk     (pclk),
    .rst_n   (presetn),
    .clear   (accept),
    .enable  (state_q == ACCESS && !pready),
    .limit   (CW'(TIMEOUT)),
    .expired (expired)
  );
  // next-state and next-output logic; bus fields hold between transfers, response fields pulse
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d  = SETUP;
        psel_d   = 1'b1;
        pwrite_d = cmd_write;
        paddr_d  = cmd_addr;
        pwdata_d = cmd_write ? cmd_wdata : '0;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (pready || expired) begin
        state_d     = IDLE;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !pready;
        rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end
  // state and registered outputs; reset drops the bus at once and discards any pending response
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed and random APB transfers against a memory responder and a reference model
module tb_apb_master;
  logic pclk = 1'b0, presetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_wdata = 8'h00;
  logic cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready;
  logic [7:0] rsp_rdata, paddr, pwdata, prdata;
  logic b_cmd_valid = 1'b0, b_pready = 1'b0;
  logic [7:0] b_prdata = 8'h00;
  logic b_cmd_ready, b_rsp_valid, b_rsp_err, b_psel, b_penable, b_pwrite;
  logic [7:0] b_rsp_rdata, b_paddr, b_pwdata;
  logic [7:0] mem [256];
  logic [7:0] model [256];
  int resp_waits = 0, wcnt = 0;
  bit resp_tie = 1'b0;
  int n_cmp = 0, n_err = 0;

  always #5 pclk = ~pclk;

  apb_master #(.TIMEOUT(15)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_master #(.TIMEOUT(3)) u3 (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .paddr(b_paddr),
    .pwdata(b_pwdata), .prdata(b_prdata), .pready(b_pready)
  );

  // memory responder: pready after resp_waits stalled ACCESS cycles, never when resp_tie is set
  assign pready = psel && penable && !resp_tie && wcnt == resp_waits;
  assign prdata = mem[paddr];
  always @(posedge pclk) begin
    wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one transfer; expectations come from the command semantics and the reference memory
  task automatic do_cmd(input bit w, input logic [7:0] a, input logic [7:0] d, input int waits, input bit tie);
    int t, k, pc, ec, acc;
    bit bus_ok;
    logic [7:0] exp_rd, exp_wd;
    acc = tie ? 15 : waits + 1;
    exp_rd = (tie || w) ? 8'h00 : model[a];
    exp_wd = w ? d : 8'h00;
    if (w && !tie) model[a] = d;
    resp_waits = waits;
    resp_tie = tie;
    @(negedge pclk);
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge pclk); t++; end
    chk("cmd_ready", 32'(cmd_ready), 1);
    @(posedge pclk);
    k = 0; pc = 0; ec = 0; bus_ok = 1'b1;
    while (k < 60) begin
      @(negedge pclk);
      k++;
      cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = 8'($urandom); cmd_write = !w;
      if (rsp_valid) break;
      if (psel) pc++;
      if (penable) ec++;
      if (psel && (paddr !== a || pwrite !== w || pwdata !== exp_wd)) bus_ok = 1'b0;
    end
    chk("rsp_latency", k, acc + 2);
    chk("rsp_err", 32'(rsp_err), 32'(tie));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    chk("psel_cycles", pc, acc + 1);
    chk("penable_cycles", ec, acc);
    chk("bus_stable", 32'(bus_ok), 1);
    chk("idle_in_rsp", 32'({psel, penable}), 0);
    @(negedge pclk);
    chk("rsp_pulse", 32'(rsp_valid), 0);
    resp_tie = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    int t, nr, acc, rk;
    int acc_cyc[$];
    int cyc, idx, nrsp, nerr_rsp;
    bit r;
    for (int i = 0; i < 256; i++) begin
      v = (i == 16) ? 8'h5E : 8'($urandom);
      mem[i] <= v;
      model[i] = v;
    end
    #3;
    chk("reset_outputs", 32'({cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata}), 0);
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("ready_after_reset", 32'(cmd_ready), 1);
    chk("idle_outputs", 32'({psel, penable, rsp_valid}), 0);

    do_cmd(1'b1, 8'h3C, 8'hA5, 0, 1'b0);
    do_cmd(1'b0, 8'h3C, 8'h00, 0, 1'b0);
    do_cmd(1'b0, 8'h10, 8'h00, 2, 1'b0);
    do_cmd(1'b1, 8'h77, 8'h99, 0, 1'b1);
    do_cmd(1'b0, 8'h77, 8'h00, 1, 1'b0);

    for (int i = 0; i < 24; i++)
      do_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3), 1'b0);

    resp_waits = 0;
    cyc = 0; idx = 0; nrsp = 0; nerr_rsp = 0;
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 8'h11; cmd_valid = 1'b1;
    while (cyc < 30) begin
      r = cmd_ready && cmd_valid;
      @(posedge pclk);
      @(negedge pclk);
      cyc++;
      if (rsp_valid) begin nrsp++; if (rsp_err) nerr_rsp++; end
      if (r) begin
        acc_cyc.push_back(cyc);
        model[idx] = 8'(17 * (idx + 1));
        idx++;
        if (idx < 4) begin cmd_addr = 8'(idx); cmd_wdata = 8'(17 * (idx + 1)); end
        else cmd_valid = 1'b0;
      end
    end
    chk("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < 4; i++)
      chk("b2b_spacing", (acc_cyc.size() > i) ? acc_cyc[i] - acc_cyc[i-1] : -1, 3);
    chk("b2b_responses", nrsp, 4);
    chk("b2b_errors", nerr_rsp, 0);
    for (int i = 0; i < 4; i++) chk("b2b_mem", 32'(mem[i]), 32'(model[i]));

    resp_waits = 8;
    @(negedge pclk);
    cmd_write = 1'b1; cmd_addr = 8'h05; cmd_wdata = 8'hEE; cmd_valid = 1'b1;
    t = 0;
    while (!cmd_ready && t < 20) begin @(negedge pclk); t++; end
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    t = 0;
    while (!penable && t < 10) begin @(negedge pclk); t++; end
    chk("reach_access", 32'(penable), 1);
    #2 presetn = 1'b0;
    #1 chk("async_reset_outputs", 32'({cmd_ready, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_err, rsp_rdata}), 0);
    nr = 0;
    repeat (3) begin @(negedge pclk); if (rsp_valid) nr++; end
    presetn = 1'b1;
    repeat (3) begin @(negedge pclk); if (rsp_valid) nr++; end
    chk("no_rsp_after_abort", nr, 0);
    chk("ready_after_abort", 32'(cmd_ready), 1);
    do_cmd(1'b0, 8'h00, 8'h00, 0, 1'b0);
    do_cmd(1'b0, 8'h05, 8'h00, 0, 1'b0);

    for (int s = 0; s < 2; s++) begin
      @(negedge pclk);
      cmd_write = 1'b0; cmd_addr = 8'h20; b_cmd_valid = 1'b1; b_prdata = 8'h77;
      chk("t3_ready", 32'(b_cmd_ready), 1);
      @(posedge pclk);
      acc = 0; rk = 0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge pclk);
        b_cmd_valid = 1'b0;
        if (b_rsp_valid) begin rk = k; break; end
        if (b_penable) acc++;
        b_pready = (s == 0 && acc == 3);
      end
      b_pready = 1'b0;
      chk("t3_latency", rk, 5);
      chk("t3_err", 32'(b_rsp_err), (s == 1) ? 1 : 0);
      chk("t3_rdata", 32'(b_rsp_rdata), (s == 0) ? 32'h77 : 0);
      chk("t3_idle_in_rsp", 32'({b_psel, b_penable}), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
